// File: rtl/iterative_muldiv_unit_if.sv
// Handshake and operand/result bundle for the iterative multiply/divide unit.
// The controller drives through the master modport and the unit serves the slave modport.
interface iterative_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH-1:0] src_c;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             div_by_zero;
   logic             N;
   logic             Z;

   modport master (
      output start, op, src_a, src_b, src_c,
      input  busy, done, result, result_hi, div_by_zero, N, Z
   );

   modport slave (
      input  start, op, src_a, src_b, src_c,
      output busy, done, result, result_hi, div_by_zero, N, Z
   );
endinterface

// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle MUL/MLA/UDIV/SDIV unit: radix-2 shift-add products and restoring
// division, one iteration per clock, WIDTH iterations per operation.
module iterative_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic                    clk,
   input logic                    reset,
   iterative_muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_MLA  = 2'b01;
   localparam logic [1:0] OP_SDIV = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} stateT;

   stateT              state;
   stateT              stateNext;
   logic               divOp;
   logic               zeroDiv;
   logic               signA;
   logic               signB;
   logic [WIDTH-1:0]   aReg;
   logic [WIDTH-1:0]   bReg;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [CW-1:0]      count;
   logic               busyReg;
   logic               doneReg;
   logic               dbzReg;
   logic [WIDTH-1:0]   resLo;
   logic [WIDTH-1:0]   resHi;

   logic [2*WIDTH-1:0] mulSum;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divDiff;
   logic [2*WIDTH-1:0] divNext;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] v);
      return (v < 0) ? negate(v) : v;
   endfunction

   // Multiply: acc += shifted multiplicand when the current multiplier bit is set.
   // Divide: acc holds {remainder, dividend/quotient}; shift one bit in and trial-subtract.
   always_comb begin
      mulSum   = acc + (bReg[0] ? mcand : '0);
      divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      divDiff  = divShift - {1'b0, bReg};
      if (!divDiff[WIDTH])
         divNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         divNext = {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: begin
            if (bus.start)
               stateNext = (bus.op[1] && bus.src_b == '0) ? FINISH : RUN;
         end
         RUN: begin
            if (count == CW'(1))
               stateNext = FINISH;
         end
         FINISH:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         divOp   <= 1'b0;
         zeroDiv <= 1'b0;
         signA   <= 1'b0;
         signB   <= 1'b0;
         aReg    <= '0;
         bReg    <= '0;
         acc     <= '0;
         mcand   <= '0;
         count   <= '0;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
         dbzReg  <= 1'b0;
         resLo   <= '0;
         resHi   <= '0;
      end else begin
         doneReg <= 1'b0;
         busyReg <= (stateNext != IDLE);
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  divOp   <= bus.op[1];
                  zeroDiv <= bus.op[1] && (bus.src_b == '0);
                  signA   <= (bus.op == OP_SDIV) && bus.src_a[WIDTH-1];
                  signB   <= (bus.op == OP_SDIV) && bus.src_b[WIDTH-1];
                  aReg    <= bus.src_a;
                  count   <= CW'(WIDTH);
                  dbzReg  <= 1'b0;
                  mcand   <= {{WIDTH{1'b0}}, bus.src_a};
                  if (bus.op == OP_SDIV) begin
                     bReg <= absVal(bus.src_b);
                     acc  <= {{WIDTH{1'b0}}, absVal(bus.src_a)};
                  end else if (bus.op[1]) begin
                     bReg <= bus.src_b;
                     acc  <= {{WIDTH{1'b0}}, bus.src_a};
                  end else begin
                     bReg <= bus.src_b;
                     acc  <= (bus.op == OP_MLA) ? {{WIDTH{1'b0}}, bus.src_c} : '0;
                  end
               end
            end
            RUN: begin
               count <= count - CW'(1);
               if (divOp) begin
                  acc <= divNext;
               end else begin
                  acc   <= mulSum;
                  mcand <= mcand << 1;
                  bReg  <= bReg >> 1;
               end
            end
            FINISH: begin
               doneReg <= 1'b0 | 1'b1;
               if (zeroDiv) begin
                  resLo  <= '1;
                  resHi  <= aReg;
                  dbzReg <= 1'b1;
               end else if (divOp) begin
                  // Truncating signed division: quotient sign from both operands, remainder follows dividend.
                  resLo <= (signA ^ signB) ? negate(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                  resHi <= signA ? negate(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
               end else begin
                  resLo <= acc[WIDTH-1:0];
                  resHi <= acc[2*WIDTH-1:WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busyReg;
   assign bus.done        = doneReg;
   assign bus.result      = resLo;
   assign bus.result_hi   = resHi;
   assign bus.div_by_zero = dbzReg;
   assign bus.N           = resLo[WIDTH-1];
   assign bus.Z           = (resLo == '0);
endmodule

// File: doc/iterative_muldiv_unit.md
Name: iterative_muldiv_unit

Overview:
- Multi-cycle arithmetic unit that sits beside the ALU in the multi-cycle datapath. It adds MUL, MLA, UDIV and SDIV.
- Parametrised in operand width.
- The controller issues a one-cycle start, waits on busy, and samples the results when done pulses.
- Products use radix-2 shift-add. Quotients use restoring division. Each takes WIDTH iterations.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4). The iteration counter is sized internally to hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only when busy=0
- op  input  2  00 MUL, 01 MLA, 10 UDIV, 11 SDIV
- src_a  input  WIDTH  multiplicand / dividend
- src_b  input  WIDTH  multiplier / divisor
- src_c  input  WIDTH  MLA addend (ignored otherwise)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- result  output  WIDTH  product low half / quotient
- result_hi  output  WIDTH  product high half / remainder
- div_by_zero  output  1  last division had divisor 0
- N  output  1  result[WIDTH-1]
- Z  output  1  result == 0

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy, done, div_by_zero, result, result_hi, internal accumulators and counter all go to 0.
  - N=0, Z=1 (follow result).
  - A reset asserted mid-operation aborts it; no done is produced.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at an edge (call it T0) latches op and operands into internal registers.
  - Counter is loaded with WIDTH. busy=1 from T0.
  - Next state is RUN.
  - Exception: op is UDIV or SDIV with src_b==0. Then go straight to FINISH, which delivers done after the edge at T1.
- RUN: one iteration per edge. Counter decrements. When the counter reaches 0 (after WIDTH iterations), next state is FINISH.
- MUL:
  - 2*WIDTH accumulator starts at 0.
  - Unsigned product a*b.
  - result = low half, result_hi = high half.
- MLA:
  - Accumulator starts at src_c zero-extended.
  - result/result_hi = low/high halves of a*b+c, taken modulo 2^(2*WIDTH) (cannot overflow).
- UDIV: restoring division. result = floor(a/b), result_hi = a mod b.
- SDIV:
  - Divide the magnitudes |a| and |b| unsigned.
  - In FINISH, negate the quotient if sign(a) xor sign(b).
  - Negate the remainder if sign(a) (truncating division).
  - Most-negative / −1 wraps to the most-negative value with remainder 0. No trap is raised.
- Divide by zero:
  - result = all ones, result_hi = src_a, div_by_zero=1.
  - div_by_zero is cleared by the next accepted start.
- FINISH:
  - Registers result/result_hi and applies the sign fix-ups.
  - Next state is IDLE: busy falls and done rises on the same edge.
  - Normal operations: done is high in the cycle after the edge at T0+WIDTH+1.
- Holding results:
  - result, result_hi, N, Z and div_by_zero hold after done until the next accepted start.
  - They are not cleared at that start, only overwritten in FINISH.
- start while busy=1: ignored. Latched operands and op are unaffected.
- start during the done cycle: accepted (state is IDLE). This allows back-to-back operations.
- Source operands may change freely after T0.
- No combinational path from inputs to outputs. All outputs are registered or decoded from registered result.

Test Plan:
- Reset sequence: hold reset=0 for 2 cycles, then release → busy=0, done=0, result=0, Z=1, N=0.
- MUL 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) → done exactly 33 edges after the start edge; result=0x00000001, result_hi=0xFFFFFFFE; busy high throughout.
- MLA 3×5+7 → result=0x00000016, result_hi=0; then UDIV 100/7 issued in the done cycle → result=0x0000000E, result_hi=0x00000002, second done 33 edges later.
- SDIV:
  - −7/2 → result=0xFFFFFFFD, result_hi=0xFFFFFFFF, N=1.
  - 0x80000000/0xFFFFFFFF → result=0x80000000, result_hi=0.
- UDIV 5/0 → done 2 edges after start; result=0xFFFFFFFF, result_hi=5, div_by_zero=1. A following MUL 2×2 clears div_by_zero and gives result=4.
- Sequencing and reset:
  - start pulsed again mid-RUN with different operands → ignored; original result returned.
  - reset driven low mid-RUN → busy/done/result drop to 0 immediately (asynchronously); no done pulse after release.
